// File: rtl/div_seq.sv
// Multicycle signed restoring divider for MIPS DIV: quotient truncates toward zero,
// remainder follows the dividend's sign. Divide-by-zero finishes in one cycle with a flag.
module div_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE,
      S_ZDONE
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_mag_q;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_dvs;
   logic             r_sign_q;
   logic             r_sign_r;
   logic             r_busy;
   logic             r_done;
   logic             r_div_zero;
   logic [WIDTH-1:0] r_quot;
   logic [WIDTH-1:0] r_remd;

   logic [WIDTH-1:0] w_abs_a;
   logic [WIDTH-1:0] w_abs_b;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_trial;
   logic             w_last;

   // Magnitudes are unsigned, so the most negative operand maps to 0x80000000 without overflow.
   assign w_abs_a = dividend[WIDTH-1] ? -dividend : dividend;
   assign w_abs_b = divisor[WIDTH-1]  ? -divisor  : divisor;

   assign w_shift = {r_rem, r_mag_q[WIDTH-1]};
   assign w_trial = w_shift - {1'b0, r_dvs};
   assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_mag_q    <= '0;
         r_rem      <= '0;
         r_dvs      <= '0;
         r_sign_q   <= 1'b0;
         r_sign_r   <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
         r_quot     <= '0;
         r_remd     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done     <= 1'b0;
               r_div_zero <= 1'b0;
               if (start) begin
                  if (divisor == '0) begin
                     r_state    <= S_ZDONE;
                     r_done     <= 1'b1;
                     r_div_zero <= 1'b1;
                  end else begin
                     r_state  <= S_CALC;
                     r_busy   <= 1'b1;
                     r_mag_q  <= w_abs_a;
                     r_dvs    <= w_abs_b;
                     r_sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                     r_sign_r <= dividend[WIDTH-1];
                     r_rem    <= '0;
                     r_cnt    <= '0;
                  end
               end
            end
            S_CALC: begin
               // Negative trial (borrow into the extra bit) means restore the shifted value.
               if (!w_trial[WIDTH]) begin
                  r_rem <= w_trial[WIDTH-1:0];
               end else begin
                  r_rem <= w_shift[WIDTH-1:0];
               end
               r_mag_q <= {r_mag_q[WIDTH-2:0], ~w_trial[WIDTH]};
               r_cnt   <= r_cnt + 1'b1;
               if (w_last) begin
                  r_state <= S_FIX;
               end
            end
            S_FIX: begin
               r_quot  <= r_sign_q ? -r_mag_q : r_mag_q;
               r_remd  <= r_sign_r ? -r_rem : r_rem;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= S_DONE;
            end
            S_DONE, S_ZDONE: begin
               r_done     <= 1'b0;
               r_div_zero <= 1'b0;
               r_state    <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign div_zero  = r_div_zero;
   assign quotient  = r_quot;
   assign remainder = r_remd;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: expected results are queued at start and compared when done fires,
// together with latency, busy length and pulse counts.
module tb_div_seq;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_zero;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        z;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] last_q = '0;
   logic [31:0] last_r = '0;

   div_seq #(.WIDTH(32), .CNT_W(6)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: 64-bit signed divide avoids the INT_MIN/-1 overflow case.
   task automatic model(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r);
      longint la;
      longint lb;
      la = longint'($signed(a));
      lb = longint'($signed(b));
      q  = 32'(la / lb);
      r  = 32'(la % lb);
   endtask

   // Called at #1 after an edge; returns at #1 after an edge with the DUT back in IDLE.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit disturb,
                        input string name);
      exp_t        e;
      exp_t        got;
      logic [31:0] mq;
      logic [31:0] mr;
      int          first;
      int          dcnt;
      int          zcnt;
      int          bcnt;
      if (b == 32'd0) begin
         e = '{q: last_q, r: last_r, z: 1'b1};
      end else begin
         model(a, b, mq, mr);
         e = '{q: mq, r: mr, z: 1'b0};
         last_q = mq;
         last_r = mr;
      end
      sb.push_back(e);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      first = -1;
      dcnt  = 0;
      zcnt  = 0;
      bcnt  = 0;
      got   = '{q: '0, r: '0, z: 1'b0};
      for (int n = 0; n < 40; n++) begin
         if (busy) bcnt++;
         if (div_zero) zcnt++;
         if (done) begin
            dcnt++;
            if (first < 0) begin
               first = n;
               got   = '{q: quotient, r: remainder, z: div_zero};
            end
         end
         if (disturb) begin
            if (n == 5) begin
               start    = 1'b1;
               dividend = 32'd8;
               divisor  = 32'd2;
            end
            if (n == 6) start = 1'b0;
            if (n == 12) begin
               dividend = $urandom;
               divisor  = 32'd0;
            end
         end
         @(posedge clk);
         #1;
      end
      e = sb.pop_front();
      check({name, " latency"}, 32'(first), (b == 32'd0) ? 32'd0 : 32'd33);
      check({name, " busy_cycles"}, 32'(bcnt), (b == 32'd0) ? 32'd0 : 32'd33);
      check({name, " done_pulses"}, 32'(dcnt), 32'd1);
      check({name, " divzero_pulses"}, 32'(zcnt), {31'd0, e.z});
      check({name, " quotient"}, got.q, e.q);
      check({name, " remainder"}, got.r, e.r);
      check({name, " div_zero"}, {31'd0, got.z}, {31'd0, e.z});
      $display("op %s: %h / %h -> q=%h r=%h z=%0d (lat %0d)", name, a, b, got.q, got.r,
               got.z, first);
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset div_zero", {31'd0, div_zero}, 32'd0);
      check("reset quotient", quotient, 32'd0);
      check("reset remainder", remainder, 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      do_op(32'd100, 32'd7, 1'b0, "100/7");
      do_op(32'hFFFF_FFF9, 32'd2, 1'b0, "-7/2");
      do_op(32'd7, 32'hFFFF_FFFE, 1'b0, "7/-2");
      do_op(32'd100, 32'd7, 1'b0, "100/7b");
      do_op(32'd55, 32'd0, 1'b0, "55/0");
      do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "min/-1");
      do_op(32'd0, 32'd5, 1'b0, "0/5");
      do_op(32'd100, 32'd7, 1'b0, "100/7c");

      // Abort 1000/3 after ten CALC iterations with a one-cycle reset.
      start    = 1'b1;
      dividend = 32'd1000;
      divisor  = 32'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("abort busy", {31'd0, busy}, 32'd0);
      check("abort done", {31'd0, done}, 32'd0);
      check("abort quotient", quotient, 32'd0);
      check("abort remainder", remainder, 32'd0);
      reset  = 1'b0;
      last_q = '0;
      last_r = '0;
      do_op(32'd9, 32'd4, 1'b0, "9/4");

      do_op(32'd1000, 32'd3, 1'b1, "1000/3 disturbed");
      do_op(32'hFFFF_FC18, 32'd7, 1'b0, "-1000/7");
      do_op(32'h8000_0000, 32'h8000_0000, 1'b0, "min/min");
      do_op(32'd3, 32'h8000_0000, 1'b0, "3/min");
      do_op($urandom, $urandom | 32'd1, 1'b0, "random");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multicycle signed 32-bit divider for DIV. Replaces the free-running combinational-style divider feeding the HI/LO select muxes.
- The control unit issues a one-cycle start and waits for done.
- Quotient goes to LO and remainder to HI, via the existing div/mult HI/LO muxes and the HILO write enable.
- A divide-by-zero flag is produced for the exception path (EPC / exception handler).

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- dividend  input  WIDTH  signed dividend (Reg_A output); sampled with start.
- divisor  input  WIDTH  signed divisor (Reg_B output); sampled with start.
- busy  output  1  high while in CALC or FIX.
- done  output  1  one-cycle pulse; results/flag valid in this cycle.
- quotient  output  WIDTH  signed quotient (to LO mux).
- remainder  output  WIDTH  signed remainder (to HI mux).
- div_zero  output  1  one-cycle pulse coincident with done when divisor was 0.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset. All state is registered on the rising edge of clk.
- Reset values: state=IDLE; busy=0, done=0, div_zero=0, quotient=0, remainder=0; counter and working registers 0.
- Reset takes priority over all other activity, including mid-CALC. The in-flight operation is discarded, no done is produced, and start is accepted on the first cycle after reset deasserts.
- States:
  - IDLE: busy=0. When start=1 is sampled at edge E0:
    - divisor==0: go to ZDONE.
    - Otherwise: latch |dividend| and |divisor|, sign_q = dividend[MSB]^divisor[MSB], sign_r = dividend[MSB], partial remainder=0, count=0, go to CALC.
  - ZDONE: done=1 and div_zero=1 for exactly this cycle (the cycle after E0). quotient/remainder keep their previous values. Next state is IDLE.
  - CALC: busy=1. Each edge performs one restoring shift-subtract step:
    - Shift {rem, mag_q} left by 1.
    - Trial subtract |divisor| at WIDTH+1 bits.
    - If the result is non-negative, keep it and set the quotient LSB to 1.
    - count++. After the step with count==WIDTH-1, go to FIX.
  - FIX: busy=1. Apply signs: quotient = sign_q ? -mag_q : mag_q; remainder = sign_r ? -rem : rem (two's complement, truncated to WIDTH). Register both and go to DONE.
  - DONE: done=1 and div_zero=0 for one cycle. busy=0. Next state is IDLE.
- Latency:
  - Normal: start sampled at E0, 32 CALC edges (E1..E32), FIX at E33; done is high between E33 and E34, i.e. 33 cycles.
  - Divide by zero: done high between E0 and E1, i.e. 1 cycle.
- Semantics: MIPS DIV. The quotient truncates toward zero and the remainder takes the dividend's sign; |remainder| < |divisor|.
  - |-2^31| is represented as 0x80000000 at WIDTH+1-bit precision internally.
  - 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000 and remainder 0, with no flag.
- start while busy (CALC/FIX) or in DONE/ZDONE is ignored; no queueing.
- Operands are captured at E0. Later changes on dividend/divisor do not affect the result.
- quotient/remainder hold their values from the last successful division until the next FIX or reset. They are never partially updated during CALC.
- done and div_zero never assert outside the DONE/ZDONE cycle. There are no back-to-back done pulses without a new start.
- Back-to-back operation: start may be reissued in the cycle after done (IDLE).

Test Plan:
- Reset, then start with 100 / 7 → busy high E1..E33; done pulse 33 cycles after start; quotient=14, remainder=2; div_zero=0.
- start with 0xFFFFFFF9 (-7) / 2 → quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Then 7 / 0xFFFFFFFE (-2) → quotient=0xFFFFFFFD, remainder=1.
- After a 100/7 result, start with 55 / 0 → done and div_zero both high in the next cycle only; quotient stays 14, remainder stays 2; busy never rises.
- start with 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0, div_zero=0. Then 0 / 5 → quotient=0, remainder=0.
- Assert reset for one cycle at CALC iteration 10 of 1000/3 → next cycle busy=0 and outputs 0; no done. Start 9/4 on the following cycle → quotient=2, remainder=1 after 33 cycles.
- During a 1000/3 operation, pulse start with 8/2 and toggle the operand inputs mid-CALC → exactly one done; quotient=333, remainder=1.
